// File: rtl/filter_loader.sv
// rtl/filter_loader.sv - streams nine filter weights from the filter buffer into the convolver shift register
module filter_loader #(
   parameter int WID      = 16,
   parameter int ADDR_W   = 10,
   parameter int NUM_TAPS = 9,
   parameter int RD_LAT   = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_clear,
   input  logic [ADDR_W-1:0] i_base_addr,
   output logic              o_mem_rd_en,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [WID-1:0]    i_mem_rd_data,
   output logic [WID-1:0]    o_sr_data,
   output logic              o_sr_shift,
   output logic              o_busy,
   output logic              o_done
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;

   // Weights are issued from the highest index down so that w[0] is shifted in last.
   localparam logic [3:0] LAST_IDX = 4'(NUM_TAPS - 1);
   localparam logic [3:0] TAP_CNT  = 4'(NUM_TAPS);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_issue_cnt;
   logic [3:0]        w_issue_cnt_nxt;
   logic [3:0]        r_shift_cnt;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] w_base_nxt;
   logic              r_mem_rd_en;
   logic              w_rd_en_nxt;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic              r_busy;
   logic              w_busy_nxt;
   logic              r_done;
   logic              w_done_nxt;
   logic [RD_LAT-1:0] r_vpipe;
   logic [RD_LAT:0]   w_vcat;
   logic [WID-1:0]    r_sr_data;
   logic              r_sr_shift;

   assign o_mem_rd_en = r_mem_rd_en;
   assign o_mem_addr  = r_mem_addr;
   assign o_sr_data   = r_sr_data;
   assign o_sr_shift  = r_sr_shift;
   assign o_busy      = r_busy;
   assign o_done      = r_done;

   // Read-valid pipe input: the issued read enable enters at the bottom.
   assign w_vcat = {r_vpipe, r_mem_rd_en};

   // State register and registered control outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_issue_cnt <= 4'd0;
         r_base      <= '0;
         r_mem_rd_en <= 1'b0;
         r_mem_addr  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_issue_cnt <= w_issue_cnt_nxt;
         r_base      <= w_base_nxt;
         r_mem_rd_en <= w_rd_en_nxt;
         r_mem_addr  <= w_addr_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
      end
   end

   // Next-state and next-output decode; clear overrides everything, including start.
   always_comb begin
      w_state_nxt     = r_state;
      w_issue_cnt_nxt = r_issue_cnt;
      w_base_nxt      = r_base;
      w_rd_en_nxt     = 1'b0;
      w_addr_nxt      = r_mem_addr;
      w_busy_nxt      = r_busy;
      w_done_nxt      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_base_nxt      = i_base_addr;
               w_issue_cnt_nxt = LAST_IDX;
               w_busy_nxt      = 1'b1;
               w_state_nxt     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_rd_en_nxt = 1'b1;
            w_addr_nxt  = r_base + ADDR_W'(r_issue_cnt);
            if (r_issue_cnt == 4'd0) begin
               w_state_nxt = S_DRAIN;
            end else begin
               w_issue_cnt_nxt = r_issue_cnt - 4'd1;
            end
         end
         S_DRAIN: begin
            // The last weight is on sr_data this cycle; the filter is complete.
            if (r_sr_shift && (r_shift_cnt == TAP_CNT)) begin
               w_state_nxt = S_FINISH;
               w_done_nxt  = 1'b1;
            end
         end
         S_FINISH: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (i_clear) begin
         w_state_nxt = S_IDLE;
         w_rd_en_nxt = 1'b0;
         w_busy_nxt  = 1'b0;
         w_done_nxt  = 1'b0;
      end
   end

   // Read-valid tracking: capture returning data and strobe the shift register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_vpipe     <= '0;
         r_sr_data   <= '0;
         r_sr_shift  <= 1'b0;
         r_shift_cnt <= 4'd0;
      end else if (i_clear) begin
         r_vpipe     <= '0;
         r_sr_shift  <= 1'b0;
         r_shift_cnt <= 4'd0;
      end else begin
         r_vpipe <= w_vcat[RD_LAT-1:0];
         if (r_vpipe[RD_LAT-1]) begin
            r_sr_data   <= i_mem_rd_data;
            r_sr_shift  <= 1'b1;
            r_shift_cnt <= r_shift_cnt + 4'd1;
         end else begin
            r_sr_shift <= 1'b0;
            if (r_state == S_IDLE) begin
               r_shift_cnt <= 4'd0;
            end
         end
      end
   end

endmodule

// File: tb/tb_filter_loader.sv
// tb/tb_filter_loader.sv - randomized self-checking bench for filter_loader at read latencies 1 and 2
module tb_filter_loader;

   localparam int AW = 10;
   localparam int W  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              clear;
   logic [AW-1:0]     base;
   logic [1:0]        start;
   logic [1:0]        rd_en;
   logic [1:0][AW-1:0] addr;
   logic [1:0][W-1:0]  rdata;
   logic [1:0][W-1:0]  sdata;
   logic [1:0]        shift;
   logic [1:0]        busy;
   logic [1:0]        done;
   logic [W-1:0]      p2;

   logic [W-1:0] mem [1024];
   logic [W-1:0] sreg [2][9];

   int n_cmp = 0;
   int n_bad = 0;

   filter_loader #(.WID(W), .ADDR_W(AW), .NUM_TAPS(9), .RD_LAT(1)) u_lat1 (
      .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_clear(clear), .i_base_addr(base),
      .o_mem_rd_en(rd_en[0]), .o_mem_addr(addr[0]), .i_mem_rd_data(rdata[0]),
      .o_sr_data(sdata[0]), .o_sr_shift(shift[0]), .o_busy(busy[0]), .o_done(done[0])
   );

   filter_loader #(.WID(W), .ADDR_W(AW), .NUM_TAPS(9), .RD_LAT(2)) u_lat2 (
      .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_clear(clear), .i_base_addr(base),
      .o_mem_rd_en(rd_en[1]), .o_mem_addr(addr[1]), .i_mem_rd_data(rdata[1]),
      .o_sr_data(sdata[1]), .o_sr_shift(shift[1]), .o_busy(busy[1]), .o_done(done[1])
   );

   // Filter buffer models; data outside a valid read window is garbage.
   always @(posedge clk) begin
      rdata[0] <= rd_en[0] ? mem[addr[0]] : W'($urandom);
      p2       <= rd_en[1] ? mem[addr[1]] : W'($urandom);
      rdata[1] <= p2;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s d%0d rd_en", tag, d), rd_en[d], 0);
         chk($sformatf("%s d%0d addr", tag, d), addr[d], 0);
         chk($sformatf("%s d%0d sr_data", tag, d), sdata[d], 0);
         chk($sformatf("%s d%0d sr_shift", tag, d), shift[d], 0);
         chk($sformatf("%s d%0d busy", tag, d), busy[d], 0);
         chk($sformatf("%s d%0d done", tag, d), done[d], 0);
      end
   endtask

   // One load on both latencies; optional clear, async reset, ignored start, and back-to-back reload.
   task automatic run_load(input logic [AW-1:0] b, input int clr_cyc, input int rst_cyc,
                           input bit busy_start, input bit b2b, input logic [AW-1:0] b2);
      int  k0 [2];
      int  bcur [2];
      bit  killed;
      int  kend;
      k0[0] = 0; k0[1] = 0;
      bcur[0] = int'(b); bcur[1] = int'(b);
      killed = 1'b0;
      kend = b2b ? 32 : 16;
      @(negedge clk);
      base  = b;
      start = 2'b11;
      @(posedge clk);
      for (int k = 0; k <= kend; k++) begin
         @(negedge clk);
         start = 2'b00;
         clear = 1'b0;
         for (int d = 0; d < 2; d++) begin
            int L;
            int kk;
            bit e_rd, e_sh, e_done, e_busy;
            L  = d + 1;
            kk = k - k0[d];
            e_rd   = (kk >= 1) && (kk <= 9);
            e_sh   = (kk >= 2 + L) && (kk <= 10 + L);
            e_done = (kk == 11 + L);
            e_busy = (kk >= 0) && (kk <= 11 + L);
            if (killed) begin
               e_rd = 0; e_sh = 0; e_done = 0; e_busy = 0;
            end
            chk($sformatf("d%0d k%0d rd_en", d, k), rd_en[d], e_rd);
            chk($sformatf("d%0d k%0d sr_shift", d, k), shift[d], e_sh);
            chk($sformatf("d%0d k%0d done", d, k), done[d], e_done);
            chk($sformatf("d%0d k%0d busy", d, k), busy[d], e_busy);
            if (e_rd)
               chk($sformatf("d%0d k%0d addr", d, k), addr[d], (bcur[d] + 9 - kk) & 1023);
            if (e_sh)
               chk($sformatf("d%0d k%0d sr_data", d, k), sdata[d], mem[(bcur[d] + 10 + L - kk) & 1023]);
            if (shift[d]) begin
               for (int j = 8; j > 0; j--) sreg[d][j] = sreg[d][j-1];
               sreg[d][0] = sdata[d];
            end
            if (b2b && k == 12 + L) begin
               start[d] = 1'b1;
               base     = b2;
               k0[d]    = 13 + L;
               bcur[d]  = int'(b2);
            end
         end
         if (busy_start && k == 5) begin
            start = 2'b11;
            base  = ~b;
         end
         if (k == clr_cyc) begin
            clear  = 1'b1;
            killed = 1'b1;
         end
         if (k == rst_cyc) begin
            #2 rst = 1'b1;
            #1 chk_idle_outputs($sformatf("async_rst k%0d", k));
            rst    = 1'b0;
            killed = 1'b1;
         end
      end
      if (!killed) begin
         for (int d = 0; d < 2; d++)
            for (int j = 0; j < 9; j++)
               chk($sformatf("d%0d out_%0d", d, j + 1), sreg[d][j], mem[(bcur[d] + j) & 1023]);
      end
   endtask

   initial begin
      rst   = 1'b1;
      clear = 1'b0;
      start = 2'b00;
      base  = '0;
      for (int i = 0; i < 1024; i++) mem[i] = W'($urandom);
      for (int i = 0; i < 9; i++) mem[32 + i] = 16'h0100 + W'(i);
      for (int d = 0; d < 2; d++)
         for (int j = 0; j < 9; j++) sreg[d][j] = '0;
      #1 chk_idle_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_load(10'h020, -1, -1, 1'b0, 1'b0, '0);
      run_load(10'h3FC, -1, -1, 1'b0, 1'b0, '0);
      run_load(AW'($urandom), -1, -1, 1'b1, 1'b1, AW'($urandom));
      run_load(AW'($urandom), 6, -1, 1'b0, 1'b0, '0);
      run_load(AW'($urandom), -1, -1, 1'b0, 1'b0, '0);
      run_load(AW'($urandom), -1, 10, 1'b0, 1'b0, '0);
      run_load(AW'($urandom), -1, -1, 1'b0, 1'b0, '0);
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < 1024; i++) mem[i] = W'($urandom);
         run_load(AW'($urandom), -1, -1, 1'($urandom), 1'b0, '0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/filter_loader.md
Name: filter_loader

Overview:
- Upstream feeder for the 9-tap convolver filter shift register.
- On a start request it reads nine consecutive filter weights from the filter buffer memory and streams them one per cycle with a shift strobe.
- After the final shift, shift-register tap out_k holds weight w[k-1], where w[i] is the word at base_addr+i.
- Pulses done when the filter is fully loaded, so the convolver can begin.

Parameters:
- WID, 16: weight width in bits; must equal `WID_FILTER.
- ADDR_W, 10: filter buffer address width.
- NUM_TAPS, 9: weights per filter; fixed at 9 for the 3x3 convolver.
- RD_LAT, 1: filter buffer read latency in cycles; legal values are 1 or 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  load request; sampled only in IDLE
- clear  in  1  synchronous abort; returns to IDLE with no done pulse
- base_addr  in  ADDR_W  address of w[0]; latched on an accepted start
- mem_rd_en  out  1  filter buffer read enable
- mem_addr  out  ADDR_W  filter buffer read address
- mem_rd_data  in  WID  read data, valid RD_LAT cycles after the mem_rd_en cycle
- sr_data  out  WID  weight to the shift register (inp_sr)
- sr_shift  out  1  shift strobe (shifting)
- busy  out  1  high from accepted start through the done cycle
- done  out  1  one-cycle pulse when loading is complete

Behaviour:
- Reset (async, rst=1): state=IDLE; mem_rd_en=0, mem_addr=0, sr_data=0, sr_shift=0, busy=0, done=0. Issue counter, valid pipe and latched base are cleared.
- All outputs are registered.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - start=1 at edge E0: latch base_addr, go to ISSUE; busy=1 from E0.
  - start while not IDLE is ignored; no queuing.
- ISSUE:
  - Exactly 9 consecutive cycles with mem_rd_en=1.
  - Addresses are issued high to low: base+8, base+7, …, base+0.
  - Address arithmetic is modulo 2^ADDR_W; wrap past the maximum address is legal.
  - A 4-bit down-counter tracks issue; leaving ISSUE drives mem_rd_en=0 and moves to DRAIN.
- Read valid tracking: an RD_LAT-deep shift pipe carries mem_rd_en. When the pipe output is 1, register sr_data<=mem_rd_data and sr_shift<=1; otherwise sr_shift<=0 and sr_data holds.
- DRAIN: waits until the 9th sr_shift has been driven, then moves to FINISH.
- FINISH: done=1 for one cycle, busy=0 next edge, return to IDLE. Back-to-back start is accepted in the cycle after FINISH.
- Timing, relative to E0:
  - mem_rd_en high in cycles 1..9.
  - sr_shift high in cycles 2+RD_LAT .. 10+RD_LAT (9 consecutive cycles, no gaps).
  - done in cycle 11+RD_LAT.
- Ordering: the first weight shifted is w[8], the last is w[0]. After loading, out_9=w[8] … out_1=w[0].
- clear=1 in any state: next edge goes to IDLE. It forces mem_rd_en=0, sr_shift=0, busy=0 and done=0, and flushes the valid pipe, so no in-flight data is shifted. clear has priority over start in the same cycle.
- Reset mid-operation: immediate return to the reset values listed above. Downstream shift-register contents are undefined until a new load.

Test Plan:
- Basic load (RD_LAT=1):
  - Stimulus: mem[i]=16'h0100+i for i=0..8, base=0x020, start pulse at E0.
  - Required: mem_addr = 0x028..0x020 in cycles 1..9; sr_shift high in cycles 3..11; sr_data sequence 0x0108 down to 0x0100; done in cycle 12; shift register then holds out_1=0x0100 … out_9=0x0108.
- RD_LAT=2:
  - Stimulus: same as basic load.
  - Required: sr_shift in cycles 4..12, done in cycle 13, same data order.
- Address wrap:
  - Stimulus: base=0x3FC, ADDR_W=10.
  - Required: addresses 0x004,0x003,0x002,0x001,0x000,0x3FF,0x3FE,0x3FD,0x3FC.
- start while busy:
  - Stimulus: second start in cycle 5, then another start in the cycle after FINISH.
  - Required: the cycle-5 start is ignored (exactly 9 reads, one done); the post-FINISH start begins a new load.
- clear mid-stream:
  - Stimulus: clear in cycle 6.
  - Required: mem_rd_en=0 and sr_shift=0 from cycle 7; no done; busy=0; a new start then loads correctly.
- Async reset in DRAIN:
  - Stimulus: rst pulsed asynchronously while in DRAIN.
  - Required: all outputs 0 immediately; FSM in IDLE; a subsequent load completes normally.
